uart_loader: RTL and testbench

Boot-time program loader that sequences the UART receiver's byte stream into instruction-memory writes. It holds the CPU core in reset while a framed image arrives over UART, assembles little-endian 32-bit words, and writes them to sequential word addresses. When the frame completes, it releases the CPU. It sits between the UART receiver's byte/fin outputs and the instruction-memory write port, and drives the core's reset.

---
 rtl/uart_loader.sv | 152 +++++++++++++++
 tb/tb_uart_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// uart_loader: UART boot loader, packs LE words into imem and holds CPU in reset; checksum byte with UART_LOADER_CHECKSUM_EN
module uart_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rxData,
  input  logic                  rxFin,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWdata,
  output logic                  cpuResetN,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM} state_t;
  state_t state, state_n;
  logic rx_fin_q, accept, ok, fin, fail, too_long, last;
  logic [15:0] len, len_n, len_hi;
  logic [ADDR_WIDTH-1:0] word_idx, word_idx_n, addr_n;
  logic [1:0] byte_idx, byte_idx_n;
  logic [31:0] word, word_n, wdata_n, tcnt, tcnt_n;
  logic we_n, cpu_n, busy_n, done_n, error_n;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] csum, csum_n;
`endif
  assign accept = rxFin & ~rx_fin_q;
  assign len_hi = {rxData, len[7:0]};
  assign too_long = 32'(len_hi) > (32'd1 << ADDR_WIDTH);
  assign last = 32'(word_idx) + 32'd1 == 32'(len);
  always_comb begin
    state_n = state;
    len_n = len;
    word_idx_n = word_idx;
    byte_idx_n = byte_idx;
    word_n = word;
    we_n = 1'b0;
    addr_n = memAddr;
    wdata_n = memWdata;
    cpu_n = cpuResetN;
    done_n = done;
    error_n = error;
    ok = 1'b0;
    fin = 1'b0;
    fail = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
    csum_n = csum;
`endif
    if (accept) begin
      case (state)
        IDLE: if (rxData == SYNC_BYTE) begin
          state_n = LEN_LO;
          done_n = 1'b0;
          error_n = 1'b0;
          cpu_n = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_n = 8'h00;
`endif
        end
        LEN_LO: begin
          len_n = {8'h00, rxData};
          state_n = LEN_HI;
        end
        LEN_HI: begin
          len_n = len_hi;
          if (too_long) fail = 1'b1;
          else if (len_hi == 16'd0) fin = 1'b1;
          else begin
            state_n = DATA;
            word_idx_n = '0;
            byte_idx_n = 2'd0;
          end
        end
        DATA: begin
          word_n[{byte_idx, 3'b000} +: 8] = rxData;
          byte_idx_n = byte_idx + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_n = csum ^ rxData;
`endif
          if (byte_idx == 2'd3) begin
            we_n = 1'b1;
            addr_n = word_idx;
            wdata_n = word_n;
            word_idx_n = word_idx + 1'b1;
            fin = last;
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        CSUM: if (rxData == csum) ok = 1'b1; else fail = 1'b1;
`endif
        default: ;
      endcase
    end else if (state != IDLE && tcnt == 32'(TIMEOUT_CYCLES - 1)) fail = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
    if (fin) state_n = CSUM;
`else
    ok = fin;
`endif
    if (ok) begin
      done_n = 1'b1;
      cpu_n = 1'b1;
      state_n = IDLE;
    end
    if (fail) begin
      error_n = 1'b1;
      state_n = IDLE;
    end
    tcnt_n = (accept || state_n == IDLE) ? 32'd0 : tcnt + 32'd1;
    busy_n = state_n != IDLE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      rx_fin_q <= 1'b0;
      len <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word <= '0;
      tcnt <= '0;
      memWe <= 1'b0;
      memAddr <= '0;
      memWdata <= '0;
      cpuResetN <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      state <= state_n;
      rx_fin_q <= rxFin;
      len <= len_n;
      word_idx <= word_idx_n;
      byte_idx <= byte_idx_n;
      word <= word_n;
      tcnt <= tcnt_n;
      memWe <= we_n;
      memAddr <= addr_n;
      memWdata <= wdata_n;
      cpuResetN <= cpu_n;
      busy <= busy_n;
      done <= done_n;
      error <= error_n;
`ifdef UART_LOADER_CHECKSUM_EN
      csum <= csum_n;
`endif
    end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: randomized frames against a byte-stream parser model with a write scoreboard
module tb_uart_loader;
  localparam int AW = 12, T = 64;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b0, rxFin = 1'b0;
  logic [7:0] rxData = 8'h00;
  logic memWe, cpuResetN, busy, done, error;
  logic [AW-1:0] memAddr;
  logic [31:0] memWdata;
  int pass_cnt = 0, total = 0;
  logic [AW+31:0] exp_q[$];
  logic [7:0] frm[$];

  uart_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .rxData(rxData), .rxFin(rxFin),
    .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .cpuResetN(cpuResetN), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clock)
    if (memWe) begin
      if (!reset || exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write expected", memAddr, memWdata);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(memAddr), 32'(e[AW+31:32]));
        chk("write_data", memWdata, e[31:0]);
      end
    end

  // Parses frm as a byte stream; queues the writes it implies. 1 = success, 0 = error, -1 = unfinished.
  function automatic int model();
    int i = 0, n;
    logic [7:0] x = 8'h00;
    while (i < frm.size() && frm[i] != 8'hA5) i++;
    if (i + 2 >= frm.size()) return -1;
    n = int'(frm[i+1]) + 256 * int'(frm[i+2]);
    i += 3;
    if (n > (1 << AW)) return 0;
    for (int w = 0; w < n; w++) begin
      if (i + 3 >= frm.size()) return -1;
      x ^= frm[i] ^ frm[i+1] ^ frm[i+2] ^ frm[i+3];
      exp_q.push_back({w[AW-1:0], frm[i+3], frm[i+2], frm[i+1], frm[i]});
      i += 4;
    end
    if (!CK) return 1;
    if (i >= frm.size()) return -1;
    return frm[i] == x ? 1 : 0;
  endfunction

  task automatic frame(input logic [7:0] pay[$], input int n, input bit bad);
    logic [7:0] x = 8'h00;
    frm.delete();
    frm.push_back(8'hA5);
    frm.push_back(n[7:0]);
    frm.push_back(n[15:8]);
    foreach (pay[k]) begin
      frm.push_back(pay[k]);
      x ^= pay[k];
    end
    if (CK) frm.push_back(bad ? ~x : x);
  endtask

  task automatic rand_pay(output logic [7:0] pay[$], input int n);
    pay.delete();
    repeat (4 * n) pay.push_back(8'($urandom));
  endtask

  task automatic send(input int hi, input int lo);
    foreach (frm[k]) begin
      int h, l;
      h = hi != 0 ? hi : $urandom_range(1, 3);
      l = lo != 0 ? lo : $urandom_range(1, 3);
      rxData = frm[k];
      rxFin = 1'b1;
      repeat (h) @(negedge clock);
      rxFin = 1'b0;
      rxData = 8'($urandom);
      repeat (l) @(negedge clock);
    end
  endtask

  task automatic run(input int hi, input int lo, input string tag);
    int r;
    r = model();
    send(hi, lo);
    chk({tag, " done"}, 32'(done), 32'(r == 1));
    chk({tag, " error"}, 32'(error), 32'(r == 0));
    chk({tag, " cpuResetN"}, 32'(cpuResetN), 32'(r == 1));
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " memWe"}, 32'(memWe), 32'd0);
    chk({tag, " memAddr"}, 32'(memAddr), 32'd0);
    chk({tag, " memWdata"}, memWdata, 32'd0);
    chk({tag, " cpuResetN"}, 32'(cpuResetN), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " error"}, 32'(error), 32'd0);
  endtask

  initial begin
    logic [7:0] pay[$];
    int n;
    repeat (3) @(negedge clock);
    chk_reset("reset");
    reset = 1'b1;
    @(negedge clock);
    pay = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    frame(pay, 2, 1'b0);
    run(0, 0, "frameA");
    chk("frameA hold addr", 32'(memAddr), 32'd1);
    chk("frameA hold data", memWdata, 32'hDEADBEEF);
    pay = {8'h01, 8'h02, 8'h03, 8'h04};
    frame(pay, 1, 1'b0);
    frm.push_front(8'h11);
    frm.push_front(8'hFF);
    frm.push_front(8'h00);
    run(0, 0, "garbage");
    frm = {8'hA5, 8'h01, 8'h10};
    run(0, 0, "oversize");
    rand_pay(pay, 2);
    frame(pay, 2, 1'b0);
    run(0, 0, "recover");
    pay.delete();
    frame(pay, 0, 1'b0);
    run(0, 0, "zero_len");
    frm = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56};
    void'(model());
    send(1, 1);
    chk("timeout busy", 32'(busy), 32'd1);
    repeat (T - 2) @(negedge clock);
    chk("pre_timeout busy", 32'(busy), 32'd1);
    chk("pre_timeout error", 32'(error), 32'd0);
    @(negedge clock);
    chk("timeout error", 32'(error), 32'd1);
    chk("timeout busy_low", 32'(busy), 32'd0);
    chk("timeout cpuResetN", 32'(cpuResetN), 32'd0);
    rand_pay(pay, 3);
    frame(pay, 3, 1'b0);
    run(10, 1, "held");
    rand_pay(pay, 3);
    frame(pay, 3, 1'b0);
    run(1, 1, "fast");
    rand_pay(pay, 2);
    frame(pay, 2, 1'b0);
    while (frm.size() > 6) void'(frm.pop_back());
    send(1, 1);
    reset = 1'b0;
    @(negedge clock);
    chk_reset("midreset");
    reset = 1'b1;
    @(negedge clock);
    rand_pay(pay, 2);
    frame(pay, 2, 1'b0);
    run(0, 0, "after_reset");
`ifdef UART_LOADER_CHECKSUM_EN
    rand_pay(pay, 2);
    frame(pay, 2, 1'b1);
    run(0, 0, "bad_csum");
`endif
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(0, 6);
      rand_pay(pay, n);
      frame(pay, n, CK && $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) frm.push_front(8'($urandom_range(0, 8'hA4)));
      run(0, 0, "random");
    end
    repeat (2) @(negedge clock);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
